// File: rtl/rv32v_types_pkg.sv
// Shared vector-unit types: element widths, offsets and the writeback-FIFO entry.
package rv32v_types_pkg;
  localparam int NUM_LANES    = 2;
  localparam int VLMAX        = 32;
  localparam int WB_DEPTH_DEF = 4;
  localparam int VL_WIDTH     = $clog2(VLMAX) + 1;

  typedef logic [VL_WIDTH-1:0] offset_t;

  typedef enum logic [1:0] {SEW8 = 2'd0, SEW16 = 2'd1, SEW32 = 2'd2} sew_t;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} seq_state_t;

  typedef struct packed {
    offset_t               offset;
    logic [NUM_LANES-1:0]  lane_en;
  } wb_entry_t;
endpackage

// File: rtl/rv32v_wb_offset_fifo.sv
// In-flight beat FIFO: remembers each issued beat's offset and lane mask until writeback.
module rv32v_wb_offset_fifo
  import rv32v_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      i_clear,
  input  logic      i_push,
  input  wb_entry_t i_push_data,
  input  logic      i_pop,
  output logic      o_full,
  output logic      o_empty,
  output logic      o_one,
  output wb_entry_t o_head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr, r_rptr;
  wb_entry_t   r_mem [DEPTH];
  logic        w_push, w_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_one   = ((r_wptr - r_rptr) == (AW+1)'(1));
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_push_data;
  end
endmodule

// File: rtl/rv32v_vreg_sequencer.sv
// Steps one vector op across the register file NUM_LANES elements per beat and
// pairs in-order execute results with the offsets they were issued at.
module rv32v_vreg_sequencer
  import rv32v_types_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEF
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [4:0]           op_vs1,
  input  logic [4:0]           op_vs2,
  input  logic [4:0]           op_vd,
  input  sew_t                 op_sew,
  input  logic [VL_WIDTH-1:0]  op_vl,
  input  logic                 flush,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [4:0]           vs1,
  output logic [4:0]           vs2,
  output offset_t              vs1_offset,
  output offset_t              vs2_offset,
  output logic [NUM_LANES-1:0] lane_en,
  output sew_t                 sew,
  input  logic                 wb_valid,
  output logic [4:0]           vd,
  output offset_t              vd_offset,
  output logic                 wen,
  output logic [NUM_LANES-1:0] wb_lane_en,
  output logic [VL_WIDTH-1:0]  vl,
  output logic                 done
);
  seq_state_t          r_state, w_state_nxt;
  offset_t             r_elem_idx;
  logic [4:0]          r_vs1, r_vs2, r_vd;
  sew_t                r_sew;
  logic [VL_WIDTH-1:0] r_vl;
  logic                r_done, w_done_nxt;
  logic                w_accept, w_rd_fire, w_last;
  logic                w_full, w_empty, w_one;
  logic [NUM_LANES-1:0] w_lane_en;
  wb_entry_t           w_head;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign w_lane_en[i] = (r_elem_idx + VL_WIDTH'(i)) < r_vl;
  end

  assign op_ready   = (r_state == IDLE);
  assign w_accept   = op_valid & op_ready & ~flush;
  assign rd_valid   = (r_state == ISSUE) & ~w_full;
  assign w_rd_fire  = rd_valid & rd_ready;
  assign w_last     = (r_elem_idx + VL_WIDTH'(NUM_LANES)) >= r_vl;
  assign wen        = wb_valid & ~w_empty;

  assign vs1        = r_vs1;
  assign vs2        = r_vs2;
  assign vd         = r_vd;
  assign sew        = r_sew;
  assign vl         = r_vl;
  assign vs1_offset = r_elem_idx;
  assign vs2_offset = r_elem_idx;
  assign lane_en    = w_lane_en;
  assign vd_offset  = w_head.offset;
  assign wb_lane_en = w_head.lane_en;
  assign done       = r_done;

  rv32v_wb_offset_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
    .CLK         (CLK),
    .nRST        (nRST),
    .i_clear     (flush),
    .i_push      (w_rd_fire),
    .i_push_data ('{offset: r_elem_idx, lane_en: w_lane_en}),
    .i_pop       (wen),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_one       (w_one),
    .o_head      (w_head)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE:  if (w_accept) begin
               if (op_vl != '0) w_state_nxt = ISSUE;
               else             w_done_nxt  = 1'b1;
             end
      ISSUE: if (w_rd_fire && w_last) w_state_nxt = DRAIN;
      // No pushes happen in DRAIN, so popping the sole entry empties the FIFO.
      DRAIN: if (wen && w_one) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
             end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_done     <= 1'b0;
      r_elem_idx <= '0;
      r_vs1      <= '0;
      r_vs2      <= '0;
      r_vd       <= '0;
      r_sew      <= SEW8;
      r_vl       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (flush || w_accept) r_elem_idx <= '0;
      else if (w_rd_fire)    r_elem_idx <= r_elem_idx + VL_WIDTH'(NUM_LANES);
      if (w_accept) begin
        r_vs1 <= op_vs1;
        r_vs2 <= op_vs2;
        r_vd  <= op_vd;
        r_sew <= op_sew;
        r_vl  <= op_vl;
      end
    end
  end
endmodule
